// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounces mode/inc/dec buttons, stages
// hours and minutes through an edit FSM and strobes the result into the RTC.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    output logic [4:0] initial_time_hh,
    output logic [5:0] initial_time_mm,
    output logic       initial_time_valid,
    output logic [1:0] edit_field
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    // Bit 0 = mode, 1 = inc, 2 = dec
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            localparam bit HAS_RPT = (gi != 0);
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_d_reg;
            logic             press_reg;
            logic [DB_W-1:0]  db_cnt_reg;
            logic [RPT_W-1:0] rpt_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    press_reg   <= 1'b0;
                    db_cnt_reg  <= '0;
                    rpt_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;

                    if (sync2_reg == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_reg  <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end

                    // Repeat counter counts down to the next auto-repeat pulse
                    if (level_reg && !level_d_reg) begin
                        press_reg   <= 1'b1;
                        rpt_cnt_reg <= RPT_W'(REPEAT_DELAY - 1);
                    end else if (level_reg && HAS_RPT) begin
                        if (rpt_cnt_reg == '0) begin
                            press_reg   <= 1'b1;
                            rpt_cnt_reg <= RPT_W'(REPEAT_PERIOD - 1);
                        end else begin
                            press_reg   <= 1'b0;
                            rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
                        end
                    end else begin
                        press_reg   <= 1'b0;
                        rpt_cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EDIT_HH, S_EDIT_MM, S_COMMIT} state_t;

    state_t          state_reg;
    logic [4:0]      hh_reg;
    logic [5:0]      mm_reg;
    logic            valid_reg;
    logic [1:0]      field_reg;
    logic [TO_W-1:0] to_cnt_reg;

    logic any_press;
    logic step_up;
    logic step_dn;
    logic timed_out;

    // Mode dominates; simultaneous inc and dec cancel each other
    assign any_press = |press;
    assign step_up   = press[1] & ~press[2] & ~press[0];
    assign step_dn   = press[2] & ~press[1] & ~press[0];
    assign timed_out = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) && !any_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            hh_reg     <= '0;
            mm_reg     <= '0;
            valid_reg  <= 1'b0;
            field_reg  <= 2'd0;
            to_cnt_reg <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (any_press || state_reg == S_IDLE || state_reg == S_COMMIT)
                to_cnt_reg <= '0;
            else
                to_cnt_reg <= to_cnt_reg + 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (press[0]) begin
                        hh_reg    <= cur_hh;
                        mm_reg    <= cur_mm;
                        state_reg <= S_EDIT_HH;
                        field_reg <= 2'd1;
                    end
                end
                S_EDIT_HH: begin
                    if (press[0]) begin
                        state_reg <= S_EDIT_MM;
                        field_reg <= 2'd2;
                    end else if (timed_out) begin
                        state_reg <= S_IDLE;
                        field_reg <= 2'd0;
                    end else if (step_up) begin
                        hh_reg <= (hh_reg >= 5'd23) ? 5'd0 : hh_reg + 5'd1;
                    end else if (step_dn) begin
                        hh_reg <= (hh_reg == 5'd0) ? 5'd23 : hh_reg - 5'd1;
                    end
                end
                S_EDIT_MM: begin
                    if (press[0]) begin
                        state_reg <= S_COMMIT;
                        field_reg <= 2'd0;
                        valid_reg <= 1'b1;
                    end else if (timed_out) begin
                        state_reg <= S_IDLE;
                        field_reg <= 2'd0;
                    end else if (step_up) begin
                        mm_reg <= (mm_reg >= 6'd59) ? 6'd0 : mm_reg + 6'd1;
                    end else if (step_dn) begin
                        mm_reg <= (mm_reg == 6'd0) ? 6'd59 : mm_reg - 6'd1;
                    end
                end
                S_COMMIT: begin
                    state_reg <= S_IDLE;
                    field_reg <= 2'd0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    field_reg <= 2'd0;
                end
            endcase
        end
    end

    assign initial_time_hh    = hh_reg;
    assign initial_time_mm    = mm_reg;
    assign initial_time_valid = valid_reg;
    assign edit_field         = field_reg;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences checked every cycle
// against an edge-indexed behavioural model, plus literal spot checks.
module tb_time_set_ctrl;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int T    = 200;
    localparam int HMAX = 8192;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic       btn_dec  = 1'b0;
    logic [4:0] cur_hh   = '0;
    logic [5:0] cur_mm   = '0;
    logic [4:0] initial_time_hh;
    logic [5:0] initial_time_mm;
    logic       initial_time_valid;
    logic [1:0] edit_field;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .btn_mode          (btn_mode),
        .btn_inc           (btn_inc),
        .btn_dec           (btn_dec),
        .cur_hh            (cur_hh),
        .cur_mm            (cur_mm),
        .initial_time_hh   (initial_time_hh),
        .initial_time_mm   (initial_time_mm),
        .initial_time_valid(initial_time_valid),
        .edit_field        (edit_field)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // index of the next rising edge
    int rst_base = 0;   // first edge index after the latest reset release
    int tx       = 0;

    // Model state: 0 idle, 1 edit hours, 2 edit minutes, 3 commit
    int m_state  = 0;
    int m_hh     = 0;
    int m_mm     = 0;
    int m_valid  = 0;
    int last_act = 0;

    int dut_strobes = 0;
    int dut_s_hh    = -1;
    int dut_s_mm    = -1;

    bit raw_h [3][HMAX];
    bit db_h  [3][HMAX];
    bit pr_h  [3][HMAX];
    int rise_at [3];

    function automatic bit samp(int b, int k);
        if (k < 0 || k < rst_base) return 1'b0;
        return raw_h[b][k];
    endfunction

    function automatic bit dbv(int b, int k);
        if (k < 0 || k < rst_base) return 1'b0;
        return db_h[b][k];
    endfunction

    function automatic bit prs(int b, int k);
        if (k < 0 || k < rst_base) return 1'b0;
        return pr_h[b][k];
    endfunction

    // Advance the model across rising edge e
    task automatic model_step(int e);
        bit pm, pi, pd, any, all1, all0, s, rawv;
        int old, since;
        if (e >= HMAX) begin
            failures++;
            $display("FAIL history_bound edge=%0d limit=%0d", e, HMAX);
            $fatal(1, "history bound exceeded");
        end
        pm  = prs(0, e - 1);
        pi  = prs(1, e - 1);
        pd  = prs(2, e - 1);
        any = pm | pi | pd;
        old = m_state;
        m_valid = 0;
        case (m_state)
            0: if (pm) begin
                   m_hh = int'(cur_hh);
                   m_mm = int'(cur_mm);
                   m_state = 1;
               end
            1: if (pm) m_state = 2;
               else if (!any && (e - last_act) == T) m_state = 0;
               else if (pi && !pd) m_hh = (m_hh + 1) % 24;
               else if (pd && !pi) m_hh = (m_hh + 23) % 24;
            2: if (pm) begin
                   m_state = 3;
                   m_valid = 1;
               end
               else if (!any && (e - last_act) == T) m_state = 0;
               else if (pi && !pd) m_mm = (m_mm + 1) % 60;
               else if (pd && !pi) m_mm = (m_mm + 59) % 60;
            default: m_state = 0;
        endcase
        if (any || m_state != old) last_act = e;

        for (int b = 0; b < 3; b++) begin
            rawv = (b == 0) ? btn_mode : (b == 1) ? btn_inc : btn_dec;
            raw_h[b][e] = rawv;
            // Debounced level follows the last D synchronized samples once they all agree
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = e - D - 1; k <= e - 2; k++) begin
                s = samp(b, k);
                if (s) all0 = 1'b0;
                else   all1 = 1'b0;
            end
            db_h[b][e] = all1 ? 1'b1 : (all0 ? 1'b0 : dbv(b, e - 1));
            pr_h[b][e] = 1'b0;
            if (dbv(b, e - 1) && !dbv(b, e - 2)) begin
                pr_h[b][e] = 1'b1;
                rise_at[b] = e - 1;
            end else if (b != 0 && dbv(b, e - 1)) begin
                since = e - rise_at[b] - 1;
                if (since >= RD && ((since - RD) % RP) == 0) pr_h[b][e] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        int ef;
        ef = (m_state == 1) ? 1 : (m_state == 2) ? 2 : 0;
        checks++;
        if (int'(initial_time_hh) != m_hh || int'(initial_time_mm) != m_mm ||
            int'(initial_time_valid) != m_valid || int'(edit_field) != ef) begin
            failures++;
            $display("FAIL cycle_compare edge=%0d got hh=%0d mm=%0d valid=%0d field=%0d, expected hh=%0d mm=%0d valid=%0d field=%0d",
                     n - 1, initial_time_hh, initial_time_mm, initial_time_valid, edit_field,
                     m_hh, m_mm, m_valid, ef);
        end
        if (initial_time_valid) begin
            dut_strobes++;
            dut_s_hh = int'(initial_time_hh);
            dut_s_mm = int'(initial_time_mm);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step(n);
        n++;
        @(negedge clk);
        compare();
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(int b, int width, int gap);
        if (b == 0) btn_mode = 1'b1;
        else if (b == 1) btn_inc = 1'b1;
        else btn_dec = 1'b1;
        repeat (width) tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (gap) tick();
        tx++;
        $display("tx %0d btn=%0d width=%0d -> hh=%0d mm=%0d field=%0d strobes=%0d",
                 tx, b, width, initial_time_hh, initial_time_mm, edit_field, dut_strobes);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_hh", int'(initial_time_hh), 0);
        check("reset_mm", int'(initial_time_mm), 0);
        check("reset_valid", int'(initial_time_valid), 0);
        check("reset_field", int'(edit_field), 0);
        rst = 1'b0;
        rst_base = n;
        repeat (2) tick();

        // Full set sequence
        cur_hh = 5'd10; cur_mm = 6'd30;
        hold(0, 8, 10);
        check("t1_field_hh", int'(edit_field), 1);
        repeat (3) hold(1, 8, 10);
        check("t1_hh_13", int'(initial_time_hh), 13);
        hold(0, 8, 10);
        check("t1_field_mm", int'(edit_field), 2);
        repeat (2) hold(2, 8, 10);
        check("t1_mm_28", int'(initial_time_mm), 28);
        hold(0, 8, 10);
        check("t1_field_none", int'(edit_field), 0);
        check("t1_strobes", dut_strobes, 1);
        check("t1_strobe_hh", dut_s_hh, 13);
        check("t1_strobe_mm", dut_s_mm, 28);

        // Wrap-around
        cur_hh = 5'd23; cur_mm = 6'd0;
        hold(0, 8, 10);
        hold(1, 8, 10);
        hold(0, 8, 10);
        hold(2, 8, 10);
        hold(0, 8, 10);
        check("t2_strobes", dut_strobes, 2);
        check("t2_strobe_hh", dut_s_hh, 0);
        check("t2_strobe_mm", dut_s_mm, 59);

        // Debounce: short glitch rejected, long press lands on edge 8 after rise
        cur_hh = 5'd5; cur_mm = 6'd15;
        hold(0, 8, 10);
        btn_inc = 1'b1;
        repeat (3) tick();
        btn_inc = 1'b0;
        repeat (10) tick();
        check("t3_glitch_hh", int'(initial_time_hh), 5);
        btn_inc = 1'b1;
        repeat (7) tick();
        check("t3_before_effect_hh", int'(initial_time_hh), 5);
        tick();
        check("t3_effect_hh", int'(initial_time_hh), 6);
        repeat (2) tick();
        btn_inc = 1'b0;
        repeat (10) tick();
        check("t3_single_step_hh", int'(initial_time_hh), 6);
        hold(0, 8, 10);
        hold(0, 8, 10);
        check("t3_strobes", dut_strobes, 3);

        // Auto-repeat: one press plus three repeats
        cur_hh = 5'd7; cur_mm = 6'd0;
        hold(0, 8, 10);
        hold(0, 8, 10);
        check("t4_field_mm", int'(edit_field), 2);
        hold(1, 35, 12);
        check("t4_repeat_mm", int'(initial_time_mm), 4);
        check("t4_no_strobe", dut_strobes, 3);

        // Simultaneous inc and dec cancel
        btn_inc = 1'b1; btn_dec = 1'b1;
        repeat (8) tick();
        btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (10) tick();
        check("t5_incdec_mm", int'(initial_time_mm), 4);
        hold(0, 8, 10);
        check("t5_strobes", dut_strobes, 4);
        check("t5_strobe_mm", dut_s_mm, 4);

        // Mode wins over inc in the same cycle
        cur_hh = 5'd12; cur_mm = 6'd34;
        hold(0, 8, 10);
        btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (8) tick();
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (10) tick();
        check("t5_mode_wins_field", int'(edit_field), 2);
        check("t5_mode_wins_hh", int'(initial_time_hh), 12);
        repeat (T) tick();
        check("t5_timeout_field", int'(edit_field), 0);
        check("t5_timeout_keep_hh", int'(initial_time_hh), 12);
        check("t5_timeout_keep_mm", int'(initial_time_mm), 34);

        // Timeout boundary in EDIT_HH
        btn_mode = 1'b1;
        repeat (8) tick();
        btn_mode = 1'b0;
        check("t6_enter_field", int'(edit_field), 1);
        repeat (T - 1) tick();
        check("t6_before_timeout", int'(edit_field), 1);
        tick();
        check("t6_after_timeout", int'(edit_field), 0);
        check("t6_no_strobe", dut_strobes, 4);

        // Asynchronous reset mid-edit
        cur_hh = 5'd9; cur_mm = 6'd45;
        hold(0, 8, 10);
        check("t6_reedit_field", int'(edit_field), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_hh", int'(initial_time_hh), 0);
        check("t6_rst_mm", int'(initial_time_mm), 0);
        check("t6_rst_valid", int'(initial_time_valid), 0);
        check("t6_rst_field", int'(edit_field), 0);
        m_state = 0; m_hh = 0; m_mm = 0; m_valid = 0; last_act = 0;
        repeat (3) tick();
        rst = 1'b0;
        rst_base = n;
        repeat (20) tick();
        check("t6_post_rst_field", int'(edit_field), 0);
        check("t6_post_rst_strobes", dut_strobes, 4);
        hold(0, 8, 10);
        check("t6_post_rst_hh", int'(initial_time_hh), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
